bcd_display_scanner: RTL and testbench



---
 rtl/bcd_display_scanner_pkg.sv | 26 ++
 rtl/bcd_display_scanner_scan_prescaler.sv | 31 +++
 rtl/bcd_display_scanner.sv | 120 ++++++++++++
 tb/tb_bcd_display_scanner.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/bcd_display_scanner_pkg.sv
// Shared constants for the BCD display path: nibble width and the blank code
// that the downstream 7-segment decoder renders as all segments off.
package bcd_display_scanner_pkg;

    localparam int unsigned DIGIT_W    = 4;
    localparam int unsigned MAX_DIGITS = 8;
    localparam logic [DIGIT_W-1:0] BLANK_CODE = 4'b1111;

    // Bit i set when every digit at or above i is zero; digit 0 is never blanked.
    function automatic logic [MAX_DIGITS-1:0] leading_blank_mask(
        input logic [MAX_DIGITS*DIGIT_W-1:0] value
    );
        logic [MAX_DIGITS-1:0] mask;
        logic                  seen;
        mask = '0;
        seen = 1'b0;
        for (int i = MAX_DIGITS - 1; i >= 1; i--) begin
            if (value[i*DIGIT_W +: DIGIT_W] != '0) begin
                seen = 1'b1;
            end
            mask[i] = ~seen;
        end
        return mask;
    endfunction

endpackage

// File: rtl/bcd_display_scanner_scan_prescaler.sv
// Slot prescaler for the display scanner: counts 0..PRESCALE-1 and flags the
// first (guard) and last cycle of every digit slot.
module bcd_display_scanner_scan_prescaler #(
    parameter int unsigned PRESCALE = 50000
) (
    input  logic clk,
    input  logic rst_n,
    output logic slot_start,
    output logic slot_end
);

    localparam int unsigned CNT_W = $clog2(PRESCALE);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        slot_start = (cnt_q == '0);
        slot_end   = (cnt_q == CNT_W'(PRESCALE - 1));
        cnt_d      = slot_end ? '0 : cnt_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/bcd_display_scanner.sv
// Time-multiplexed multi-digit BCD display scanner with double-buffered value.
// Optional LEADING_ZERO_BLANK_EN blanks digits above the most significant nonzero one.
module bcd_display_scanner
    import bcd_display_scanner_pkg::*;
#(
    parameter int unsigned DIGITS   = 4,
    parameter int unsigned PRESCALE = 50000
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      load,
    input  logic [DIGITS*DIGIT_W-1:0] bcd_in,
    output logic                      busy,
    output logic [DIGIT_W-1:0]        digit_bcd,
    output logic [DIGITS-1:0]         digit_sel,
    output logic                      frame_tick
);

    localparam int unsigned IDX_W = $clog2(DIGITS);
    localparam int unsigned VAL_W = DIGITS * DIGIT_W;

    logic slot_start;
    logic slot_end;
    logic boundary;

    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [VAL_W-1:0]   pending_q, pending_d;
    logic [VAL_W-1:0]   display_q, display_d;
    logic               busy_q, busy_d;
    logic [DIGIT_W-1:0] bcd_q, bcd_d;
    logic [DIGITS-1:0]  sel_q, sel_d;
    logic               tick_q, tick_d;

    bcd_display_scanner_scan_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .clk        (clk),
        .rst_n      (rst_n),
        .slot_start (slot_start),
        .slot_end   (slot_end)
    );

`ifdef LEADING_ZERO_BLANK_EN
    logic [MAX_DIGITS-1:0] blank_mask;
    always_comb begin
        blank_mask = leading_blank_mask((MAX_DIGITS*DIGIT_W)'(display_d));
    end
`endif

    always_comb begin
        boundary  = slot_end && (idx_q == IDX_W'(DIGITS - 1));
        idx_d     = idx_q;
        pending_d = pending_q;
        display_d = display_q;
        busy_d    = busy_q;

        if (slot_end) begin
            idx_d = boundary ? '0 : idx_q + 1'b1;
        end

        if (boundary) begin
            // A load landing on the boundary bypasses pending; keep pending in
            // step so the next commit does not revert to an older value.
            if (load) begin
                display_d = bcd_in;
                pending_d = bcd_in;
            end else begin
                display_d = pending_q;
            end
            busy_d = 1'b0;
        end else if (load) begin
            pending_d = bcd_in;
            busy_d    = 1'b1;
        end

        tick_d = boundary;

        // Outputs are registered from next-state so they line up with cnt/idx.
        if (slot_end) begin
            sel_d = '0;
        end else if (slot_start) begin
            sel_d = DIGITS'(1) << idx_q;
        end else begin
            sel_d = sel_q;
        end

        bcd_d = display_d[idx_d*DIGIT_W +: DIGIT_W];
`ifdef LEADING_ZERO_BLANK_EN
        if (blank_mask[3'(idx_d)]) begin
            bcd_d = BLANK_CODE;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q     <= '0;
            pending_q <= '0;
            display_q <= '0;
            busy_q    <= 1'b0;
            bcd_q     <= BLANK_CODE;
            sel_q     <= '0;
            tick_q    <= 1'b0;
        end else begin
            idx_q     <= idx_d;
            pending_q <= pending_d;
            display_q <= display_d;
            busy_q    <= busy_d;
            bcd_q     <= bcd_d;
            sel_q     <= sel_d;
            tick_q    <= tick_d;
        end
    end

    assign busy       = busy_q;
    assign digit_bcd  = bcd_q;
    assign digit_sel  = sel_q;
    assign frame_tick = tick_q;

endmodule

// File: tb/tb_bcd_display_scanner.sv
// Directed self-checking bench for bcd_display_scanner (DIGITS=4, PRESCALE=4).
// Honours LEADING_ZERO_BLANK_EN when the same macro is defined for the build.
module tb_bcd_display_scanner;

    localparam int unsigned DIGITS   = 4;
    localparam int unsigned PRESCALE = 4;

    logic        clk;
    logic        rst_n;
    logic        load;
    logic [15:0] bcd_in;
    logic        busy;
    logic [3:0]  digit_bcd;
    logic [3:0]  digit_sel;
    logic        frame_tick;

    int checks;
    int errors;
    int k;  // cycles since reset release, sampled at negedge

    bcd_display_scanner #(
        .DIGITS   (DIGITS),
        .PRESCALE (PRESCALE)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (load),
        .bcd_in     (bcd_in),
        .busy       (busy),
        .digit_bcd  (digit_bcd),
        .digit_sel  (digit_sel),
        .frame_tick (frame_tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, k);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        k++;
    endtask

    task automatic tick_to(input int target);
        while (k < target) tick();
    endtask

    // Starts on a frame's first cycle; exp nibble s is the value shown in slot s.
    task automatic check_frame(input string tag, input logic [15:0] exp);
        for (int s = 0; s < 4; s++) begin
            check_eq({tag, " guard sel"}, 16'(digit_sel), 16'h0);
            check_eq({tag, " bcd"}, 16'(digit_bcd), 16'(exp[s*4 +: 4]));
            check_eq({tag, " tick"}, 16'(frame_tick), (s == 0) ? 16'h1 : 16'h0);
            tick();
            check_eq({tag, " sel"}, 16'(digit_sel), 16'(4'b0001 << s));
            check_eq({tag, " bcd hold"}, 16'(digit_bcd), 16'(exp[s*4 +: 4]));
            tick_to(k + 3);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        k      = 0;
        rst_n  = 1'b0;
        load   = 1'b0;
        bcd_in = 16'h0;

        repeat (3) @(negedge clk);
        check_eq("rst bcd", 16'(digit_bcd), 16'hF);
        check_eq("rst sel", 16'(digit_sel), 16'h0);
        check_eq("rst busy", 16'(busy), 16'h0);
        check_eq("rst tick", 16'(frame_tick), 16'h0);

        rst_n = 1'b1;
        k     = 0;
        check_eq("post-rst guard", 16'(digit_sel), 16'h0);
        for (int i = 1; i < 4; i++) begin
            tick();
            check_eq("post-rst slot0 sel", 16'(digit_sel), 16'h1);
        end

        // Mid-frame load, committed at the next frame start.
        tick_to(20);
        load   = 1'b1;
        bcd_in = 16'h1234;
        tick();
        load = 1'b0;
        check_eq("busy after load", 16'(busy), 16'h1);
        tick_to(31);
        check_eq("busy before commit", 16'(busy), 16'h1);
        tick();
        check_eq("busy at commit", 16'(busy), 16'h0);
        check_frame("f1234", 16'h1234);

        // Last write wins.
        tick_to(50);
        load   = 1'b1;
        bcd_in = 16'h1111;
        tick();
        load = 1'b0;
        tick();
        load   = 1'b1;
        bcd_in = 16'h9876;
        tick();
        load = 1'b0;
        check_eq("busy double load", 16'(busy), 16'h1);
        tick_to(64);
        check_frame("f9876", 16'h9876);

        // Load exactly on the boundary cycle (idx 3, cnt 3).
        tick_to(95);
        load   = 1'b1;
        bcd_in = 16'h0042;
        tick();
        load = 1'b0;
        check_eq("busy boundary load", 16'(busy), 16'h0);
`ifdef LEADING_ZERO_BLANK_EN
        check_frame("f0042", 16'hFF42);
`else
        check_frame("f0042", 16'h0042);
`endif
        check_eq("busy after bypass", 16'(busy), 16'h0);

        tick_to(127);
        load   = 1'b1;
        bcd_in = 16'h0000;
        tick();
        load = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
        check_frame("f0000", 16'hFFF0);
`else
        check_frame("f0000", 16'h0000);
`endif

        // Non-decimal nibbles pass through.
        tick_to(150);
        load   = 1'b1;
        bcd_in = 16'h00AB;
        tick();
        load = 1'b0;
        tick_to(160);
`ifdef LEADING_ZERO_BLANK_EN
        check_frame("f00AB", 16'hFFAB);
`else
        check_frame("f00AB", 16'h00AB);
`endif

        // Reset mid-slot with a pending value.
        tick_to(180);
        load   = 1'b1;
        bcd_in = 16'h5555;
        tick();
        load = 1'b0;
        tick();
        check_eq("busy before rst", 16'(busy), 16'h1);
        rst_n = 1'b0;
        #1;
        check_eq("mid rst bcd", 16'(digit_bcd), 16'hF);
        check_eq("mid rst sel", 16'(digit_sel), 16'h0);
        check_eq("mid rst busy", 16'(busy), 16'h0);
        check_eq("mid rst tick", 16'(frame_tick), 16'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        k     = 0;
        check_eq("re-rst guard", 16'(digit_sel), 16'h0);
        tick();
        check_eq("re-rst sel", 16'(digit_sel), 16'h1);
        tick_to(16);
        check_eq("re-rst busy", 16'(busy), 16'h0);
`ifdef LEADING_ZERO_BLANK_EN
        check_frame("f-rst", 16'hFFF0);
`else
        check_frame("f-rst", 16'h0000);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
